// File: rtl/imem_line_responder.sv
// rtl/imem_line_responder.sv - instruction-cache line fill responder with fixed latency
// Word-loadable store; one request in flight, full 128-bit line returned as a single pulse.
module imem_line_responder #(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [31:0]  req_addr,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [127:0] resp_data,
  output logic [31:0]  resp_addr,
  output logic         resp_err,
  input  logic         load_en,
  input  logic [31:0]  load_addr,
  input  logic [31:0]  load_data
);
  localparam int LW = $clog2(DEPTH_LINES);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state_q;
  logic [CW-1:0]  counter_q;
  logic [29:0]    line_q;
  logic [127:0]   resp_data_q;
  logic [31:0]    resp_addr_q;
  logic           resp_err_q;
  logic [31:0]    store_q [DEPTH_LINES*4];

  logic           line_ok;
  logic           load_ok;
  logic [LW-1:0]  line_idx;
  logic [127:0]   line_d;
  logic           unused_req_bits;

  assign unused_req_bits = ^req_addr[1:0];

  assign line_ok  = {2'b00, line_q} < 32'(DEPTH_LINES);
  assign load_ok  = {2'b00, load_addr[31:2]} < 32'(DEPTH_LINES);
  assign line_idx = line_q[LW-1:0];

  // Word 0 of the line lands in the most significant lane.
  assign line_d = line_ok ? {store_q[{line_idx, 2'd0}], store_q[{line_idx, 2'd1}],
                             store_q[{line_idx, 2'd2}], store_q[{line_idx, 2'd3}]}
                          : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      line_q      <= '0;
      resp_data_q <= '0;
      resp_addr_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            line_q    <= req_addr[31:2];
            counter_q <= CW'(LATENCY - 1);
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (counter_q != '0) begin
            counter_q <= counter_q - CW'(1);
          end else begin
            // Store write on this same edge is not yet visible here.
            resp_data_q <= line_d;
            resp_addr_q <= {line_q, 2'b00};
            resp_err_q  <= ~line_ok;
            state_q     <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Store is deliberately left out of reset so contents survive an aborted request.
  always_ff @(posedge clock) begin
    if (load_en && load_ok) begin
      store_q[load_addr[LW+1:0]] <= load_data;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_addr  = resp_addr_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_imem_line_responder.sv
// tb/tb_imem_line_responder.sv - randomized and directed bench for imem_line_responder
// Time-based reference model plus literal expectations for the documented scenarios.
module tb_imem_line_responder;
  localparam int DEPTH = 256;
  localparam int L     = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic [31:0]  req_addr = '0;
  logic         req_ready;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic [31:0]  resp_addr;
  logic         resp_err;
  logic         load_en = 1'b0;
  logic [31:0]  load_addr = '0;
  logic [31:0]  load_data = '0;

  imem_line_responder #(.DEPTH_LINES(DEPTH), .LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_addr(resp_addr), .resp_err(resp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: word store plus timestamps of the single outstanding request.
  logic [31:0]  mm [DEPTH*4];
  int           n = 0;
  int           next_acc = 0;
  int           cap_n = 0;
  bit           pend = 1'b0;
  logic [29:0]  p_line = '0;
  logic         e_ready = 1'b1;
  logic         e_valid = 1'b0;
  logic [127:0] e_data = '0;
  logic [31:0]  e_addr = '0;
  logic         e_err = 1'b0;

  initial for (int i = 0; i < DEPTH*4; i++) mm[i] = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend = 1'b0; next_acc = 0; n = 0;
      e_ready = 1'b1; e_valid = 1'b0; e_data = '0; e_addr = '0; e_err = 1'b0;
    end else begin
      n = n + 1;
      e_valid = 1'b0;
      if (pend && n == cap_n) begin
        pend = 1'b0;
        e_valid = 1'b1;
        e_addr = {p_line, 2'b00};
        e_err = (p_line >= 30'(DEPTH));
        if (e_err) e_data = '0;
        else e_data = {mm[p_line*4], mm[p_line*4+1], mm[p_line*4+2], mm[p_line*4+3]};
      end
      if (load_en && (load_addr[31:2] < 30'(DEPTH))) mm[load_addr % (DEPTH*4)] = load_data;
      if (req_valid && n >= next_acc) begin
        pend = 1'b1;
        p_line = req_addr[31:2];
        cap_n = n + L;
        next_acc = n + L + 2;
      end
      e_ready = (n + 1 >= next_acc);
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("req_ready", {127'd0, req_ready}, {127'd0, e_ready});
      chk("resp_valid", {127'd0, resp_valid}, {127'd0, e_valid});
      chk("resp_data", resp_data, e_data);
      chk("resp_addr", {96'd0, resp_addr}, {96'd0, e_addr});
      chk("resp_err", {127'd0, resp_err}, {127'd0, e_err});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Called at posedge+1 with the responder idle; optional load lands ld_off edges after accept.
  task automatic send_req(input logic [31:0] a, input int ld_off, input logic [31:0] ld_a,
                          input logic [31:0] ld_d, output logic [127:0] d, output logic [31:0] ra,
                          output logic e, output int lat);
    int acc;
    bit seen;
    req_valid = 1'b1; req_addr = a;
    tick();
    acc = cyc;
    req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF;
    if (ld_off > 0) begin
      for (int j = 1; j < ld_off; j++) tick();
      load_en = 1'b1; load_addr = ld_a; load_data = ld_d;
      tick();
      load_en = 1'b0;
    end
    seen = 1'b0;
    lat = -1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (resp_valid) begin
        seen = 1'b1;
        lat = cyc - acc;
      end
    end
    if (!seen) chk("resp_timeout", 128'd0, 128'd1);
    d = resp_data; ra = resp_addr; e = resp_err;
    tick();
  endtask

  logic [127:0] d;
  logic [31:0]  ra;
  logic         e;
  int           lat;
  int           rdy_cnt;
  int           vld_cnt;

  initial begin
    #1 reset = 1'b1;
    #1 cmp_en = 1'b1;
    @(negedge clock);
    chk("rst_ready", {127'd0, req_ready}, 128'd1);
    chk("rst_valid", {127'd0, resp_valid}, 128'd0);
    chk("rst_data", resp_data, 128'd0);
    chk("rst_err", {127'd0, resp_err}, 128'd0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < DEPTH*4; i++) do_load(i, 32'd0);

    do_load(32'h10, 32'h11111111);
    do_load(32'h11, 32'h22222222);
    do_load(32'h12, 32'h33333333);
    do_load(32'h13, 32'h44444444);
    send_req(32'h12, 0, 0, 0, d, ra, e, lat);
    chk("lit_lat", lat, L);
    chk("lit_data", d, 128'h11111111_22222222_33333333_44444444);
    chk("lit_addr", {96'd0, ra}, 128'h10);
    chk("lit_err", {127'd0, e}, 128'd0);

    do_load(32'h400, 32'hABCD_1234);
    send_req(32'h400, 0, 0, 0, d, ra, e, lat);
    chk("oor_err", {127'd0, e}, 128'd1);
    chk("oor_data", d, 128'd0);
    send_req(32'h0, 0, 0, 0, d, ra, e, lat);
    chk("oor_load_dropped", d, 128'd0);

    rdy_cnt = 0; vld_cnt = 0;
    req_valid = 1'b1; req_addr = 32'h10;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      rdy_cnt += int'(req_ready);
      vld_cnt += int'(resp_valid);
      @(posedge clock);
      #1 req_addr = $urandom_range(0, 32'h47F);
    end
    req_valid = 1'b0;
    chk("hold_ready_cnt", rdy_cnt, 5);
    chk("hold_pulse_cnt", vld_cnt, 5);
    tick();

    do_load(32'h20, 32'h0BAD_F00D);
    send_req(32'h20, 1, 32'h20, 32'hDEAD_BEEF, d, ra, e, lat);
    chk("load_before_cap", {96'd0, d[127:96]}, 128'hDEAD_BEEF);
    send_req(32'h20, L, 32'h20, 32'hCAFE_F00D, d, ra, e, lat);
    chk("load_on_cap", {96'd0, d[127:96]}, 128'hDEAD_BEEF);
    chk("load_on_cap_lat", lat, L);
    send_req(32'h20, 0, 0, 0, d, ra, e, lat);
    chk("load_on_cap_later", {96'd0, d[127:96]}, 128'hCAFE_F00D);

    vld_cnt = 0;
    req_valid = 1'b1; req_addr = 32'h10;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vld_cnt += int'(resp_valid);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      vld_cnt += int'(resp_valid);
    end
    chk("abort_no_pulse", vld_cnt, 0);
    tick();
    send_req(32'h11, 0, 0, 0, d, ra, e, lat);
    chk("after_abort_data", d, 128'h11111111_22222222_33333333_44444444);
    chk("after_abort_lat", lat, L);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1; req_valid = 1'b0; load_en = 1'b0;
        tick();
        reset = 1'b0;
      end else begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = $urandom_range(0, 32'h47F);
        load_en   = ($urandom_range(0, 2) == 0);
        load_addr = $urandom_range(0, 32'h47F);
        load_data = $urandom;
        tick();
      end
    end
    req_valid = 1'b0; load_en = 1'b0;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
